// File: rtl/bcd_calendar_if.sv
// Bundles the calendar's control, load payload and status signals.
// The master drives ticks and load requests; the slave is the calendar core.
interface bcd_calendar_if #(
    parameter int unsigned YEAR_DIGITS = 4
);
    localparam int unsigned YW    = 4 * YEAR_DIGITS;
    localparam int unsigned CAL_W = 20 + YW;

    logic              day_tick;
    logic              set_cal;
    logic [7:0]        set_day;
    logic [3:0]        set_weekday;
    logic [7:0]        set_month;
    logic [YW-1:0]     set_year;

    logic [7:0]        real_day;
    logic [3:0]        real_weekday;
    logic [7:0]        real_month;
    logic [YW-1:0]     real_year;
    logic [CAL_W-1:0]  full_cal;
    logic              set_ack;
    logic              set_err;
    logic              month_end;
    logic              year_end;

    modport master (
        output day_tick, set_cal, set_day, set_weekday, set_month, set_year,
        input  real_day, real_weekday, real_month, real_year, full_cal,
               set_ack, set_err, month_end, year_end
    );

    modport slave (
        input  day_tick, set_cal, set_day, set_weekday, set_month, set_year,
        output real_day, real_weekday, real_month, real_year, full_cal,
               set_ack, set_err, month_end, year_end
    );
endinterface

// File: rtl/bcd_calendar.sv
// BCD day/weekday/month/year calendar with validated load and rollover pulses.
// Define BCD_CALENDAR_LEAP_YEAR_EN to give February 29 days in leap years.
module bcd_calendar #(
    parameter  int unsigned YEAR_DIGITS = 4,
    localparam int unsigned CAL_W       = 20 + 4 * YEAR_DIGITS
) (
    input  logic           d_clk,
    input  logic           rst,
    bcd_calendar_if.slave  cal
);
    localparam int unsigned YW = 4 * YEAR_DIGITS;

`ifdef BCD_CALENDAR_LEAP_YEAR_EN
    localparam bit LEAP_EN = 1'b1;
`else
    localparam bit LEAP_EN = 1'b0;
`endif

    logic [7:0]    day_q;
    logic [3:0]    wd_q;
    logic [7:0]    month_q;
    logic [YW-1:0] year_q;
    logic          ack_q, err_q, me_q, ye_q;

    function automatic logic is_bcd8(input logic [7:0] b);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
    endfunction

    function automatic logic year_is_bcd(input logic [YW-1:0] y);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < int'(YEAR_DIGITS); i++)
            if (y[4*i +: 4] > 4'd9) ok = 1'b0;
        return ok;
    endfunction

    // Two-digit BCD value 10*t+u is divisible by 4 exactly when 2*t+u is.
    function automatic logic bcd2_div4(input logic [3:0] t, input logic [3:0] u);
        return ((5'({t, 1'b0}) + 5'(u)) & 5'd3) == 5'd0;
    endfunction

    function automatic logic is_leap(input logic [YW-1:0] y);
        logic [15:0] yp;
        yp = 16'(y);
        if (yp[7:0] != 8'h00)
            return bcd2_div4(yp[7:4], yp[3:0]);
        return bcd2_div4(yp[15:12], yp[11:8]);
    endfunction

    function automatic logic [7:0] days_in_month(input logic [7:0] m, input logic [YW-1:0] y);
        case (m)
            8'h02:                      return (LEAP_EN && is_leap(y)) ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
            default:                    return 8'h31;
        endcase
    endfunction

    function automatic logic [7:0] bcd_inc8(input logic [7:0] b);
        if (b[3:0] == 4'd9) return {4'(b[7:4] + 4'd1), 4'd0};
        return {b[7:4], 4'(b[3:0] + 4'd1)};
    endfunction

    // Ripple BCD increment; an all-nines year wraps to 1 because year 0 is illegal.
    function automatic logic [YW-1:0] year_inc(input logic [YW-1:0] y);
        logic [YW-1:0] r;
        logic          carry;
        r     = y;
        carry = 1'b1;
        for (int i = 0; i < int'(YEAR_DIGITS); i++) begin
            if (carry) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = 4'(r[4*i +: 4] + 4'd1);
                    carry       = 1'b0;
                end
            end
        end
        if (r == '0) r = YW'(1);
        return r;
    endfunction

    logic       set_ok_c;
    logic [7:0] cur_dim_c;

    always_comb begin
        set_ok_c  = is_bcd8(cal.set_day) && is_bcd8(cal.set_month) &&
                    year_is_bcd(cal.set_year) &&
                    (cal.set_weekday >= 4'd1) && (cal.set_weekday <= 4'd7) &&
                    (cal.set_month >= 8'h01) && (cal.set_month <= 8'h12) &&
                    (cal.set_year != '0) && (cal.set_day >= 8'h01) &&
                    (cal.set_day <= days_in_month(cal.set_month, cal.set_year));
        cur_dim_c = days_in_month(month_q, year_q);
    end

    // Load has priority over a same-cycle tick; reset overrides both.
    always_ff @(posedge d_clk) begin
        if (rst) begin
            day_q   <= 8'h01;
            wd_q    <= 4'd1;
            month_q <= 8'h01;
            year_q  <= YW'(1);
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            me_q    <= 1'b0;
            ye_q    <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            me_q  <= 1'b0;
            ye_q  <= 1'b0;
            if (cal.set_cal) begin
                if (set_ok_c) begin
                    day_q   <= cal.set_day;
                    wd_q    <= cal.set_weekday;
                    month_q <= cal.set_month;
                    year_q  <= cal.set_year;
                    ack_q   <= 1'b1;
                end else begin
                    err_q   <= 1'b1;
                end
            end else if (cal.day_tick) begin
                wd_q <= (wd_q == 4'd7) ? 4'd1 : 4'(wd_q + 4'd1);
                if (day_q == cur_dim_c) begin
                    day_q <= 8'h01;
                    me_q  <= 1'b1;
                    if (month_q == 8'h12) begin
                        month_q <= 8'h01;
                        year_q  <= year_inc(year_q);
                        ye_q    <= 1'b1;
                    end else begin
                        month_q <= bcd_inc8(month_q);
                    end
                end else begin
                    day_q <= bcd_inc8(day_q);
                end
            end
        end
    end

    assign cal.real_day     = day_q;
    assign cal.real_weekday = wd_q;
    assign cal.real_month   = month_q;
    assign cal.real_year    = year_q;
    assign cal.full_cal     = CAL_W'({day_q, wd_q, month_q, year_q});
    assign cal.set_ack      = ack_q;
    assign cal.set_err      = err_q;
    assign cal.month_end    = me_q;
    assign cal.year_end     = ye_q;
endmodule
